// File: rtl/wave_splitter.sv
// Four-channel de-multiplexer: collects a time-multiplexed frame into shadow
// registers and commits it atomically to a valid/ready output stage.
module wave_splitter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] q_out0,
  output logic [WIDTH-1:0] q_out1,
  output logic [WIDTH-1:0] q_out2,
  output logic [WIDTH-1:0] q_out3,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             frame_err
);

  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_RESYNC = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] shadow_q [4];
  logic [WIDTH-1:0] shadow_d [4];
  logic [WIDTH-1:0] out_q [4];
  logic [WIDTH-1:0] out_d [4];
  logic             q_valid_q, q_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             accept;

  // Only the closing beat of a frame can stall: it must wait for a free output stage.
  assign s_ready = rst || !((state_q == ST_SYNC) && (slot_q == 2'd3) && q_valid_q && !q_ready);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    frame_err_d = 1'b0;
    q_valid_d   = q_valid_q && !q_ready;

    if (accept) begin
      if (state_q == ST_SYNC) begin
        if (slot_q == 2'd3) begin
          slot_d = 2'd0;
          if (s_last) begin
            // Channel 3 goes straight from the input into the output stage.
            out_d[0]  = shadow_q[0];
            out_d[1]  = shadow_q[1];
            out_d[2]  = shadow_q[2];
            out_d[3]  = s_data;
            q_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_RESYNC;
          end
        end else if (s_last) begin
          frame_err_d = 1'b1;
          slot_d      = 2'd0;
        end else begin
          shadow_d[slot_q] = s_data;
          slot_d           = slot_q + 2'd1;
        end
      end else if (s_last) begin
        state_d = ST_SYNC;
        slot_d  = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      slot_q      <= 2'd0;
      q_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      q_valid_q   <= q_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_q[gi] <= '0;
        out_q[gi]    <= '0;
      end else begin
        shadow_q[gi] <= shadow_d[gi];
        out_q[gi]    <= out_d[gi];
      end
    end
  end

  assign q_out0    = out_q[0];
  assign q_out1    = out_q[1];
  assign q_out2    = out_q[2];
  assign q_out3    = out_q[3];
  assign q_valid   = q_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/wave_splitter.md
WAVE_SPLITTER -- requirements
Module: wave_splitter

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits for input and all channel outputs.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 s_valid  input  1  input sample present.
REQ-005 s_data  input  WIDTH  time-multiplexed sample; channel order per frame is 0,1,2,3.
REQ-006 s_last  input  1  marks final sample (channel 3) of a frame.
REQ-007 s_ready  output  1  block accepts the sample this cycle.
REQ-008 q_out0..q_out3  output  WIDTH each  de-multiplexed channel samples of the last committed frame.
REQ-009 q_valid  output  1  committed frame available on q_out0..3.
REQ-010 q_ready  input  1  downstream accepts the committed frame.
REQ-011 frame_err  output  1  one-cycle pulse on a detected framing error.

Function
REQ-012 An input beat SHALL be accepted only when s_valid and s_ready are both 1.
REQ-013 The block SHALL keep a 2-bit slot counter (0..3) giving the channel of the next accepted beat.
REQ-014 The block SHALL have two states: SYNC (collecting) and RESYNC (discarding).
REQ-015 In SYNC, an accepted beat SHALL be written to shadow register [slot], and the slot SHALL increment.
REQ-016 In SYNC, an accepted beat with slot=3 and s_last=1 SHALL commit the frame: the four shadow values go to q_out0..3 on the next edge, q_valid=1, and slot=0.
REQ-017 The commit SHALL be atomic: q_out0..3 all change on the same edge, and never change while q_valid=1 and q_ready=0.
REQ-018 In SYNC, an accepted beat with s_last=1 and slot<3 (early last) SHALL raise frame_err for one cycle, discard the partial frame, set slot=0 and stay in SYNC.
REQ-019 In SYNC, an accepted beat with slot=3 and s_last=0 (missing last) SHALL raise frame_err for one cycle, not commit, and enter RESYNC.
REQ-020 In RESYNC, accepted beats SHALL be discarded. An accepted beat with s_last=1 SHALL return the block to SYNC with slot=0.
REQ-021 s_ready SHALL be 0 only when all of these hold: state is SYNC, slot=3, q_valid=1 and q_ready=0. Otherwise s_ready SHALL be 1, combinationally.
REQ-022 q_valid SHALL clear on the edge after q_valid and q_ready are both 1, unless a new commit occurs on that same edge.
REQ-023 A commit on the same edge as a downstream accept SHALL load the new frame and keep q_valid=1.
REQ-024 Samples SHALL pass through bit-exact, with no arithmetic, truncation or sign change.
REQ-025 Latency SHALL be one clock from the accepted channel-3 beat to q_valid=1.
REQ-026 frame_err SHALL be registered, and is 1 for exactly one cycle per error event.

Reset
REQ-027 While rst=1 on a clock edge, the block SHALL enter state SYNC with slot=0 and shadow registers=0.
REQ-028 While rst=1 on a clock edge, q_out0..3=0, q_valid=0 and frame_err=0.
REQ-029 While rst=1, s_ready SHALL be 1.
REQ-030 Reset asserted mid-frame SHALL discard all partially collected samples; no commit SHALL follow reset.
REQ-031 The first accepted beat after reset deasserts SHALL be treated as channel 0.

Verification
REQ-032 Nominal frame: beats 0x0001,0x0002,0x0003,0x0004 with last on the 4th, q_ready=1 -> one cycle later q_out0..3=1,2,3,4, q_valid=1 for one cycle, frame_err never set.
REQ-033 Backpressure: q_ready=0 after a commit, second frame 0x0010..0x0013 -> s_ready=0 while the 4th beat is offered, q_out holds 1..4. Raising q_ready -> 4th beat accepted and q_out=0x10..0x13 on the next edge with q_valid staying 1.
REQ-034 Early last: s_last on the 2nd beat -> frame_err pulse, no q_valid. The next 4 beats 0xA..0xD with last -> q_out=0xA,0xB,0xC,0xD.
REQ-035 Missing last: 4 beats with no last -> frame_err pulse, RESYNC. 2 further beats (last on the 2nd) are discarded. The next correct frame commits normally.
REQ-036 Reset mid-frame: 2 beats accepted, rst pulsed for 1 cycle -> all outputs 0. The following 4-beat frame 0xFFFF,0x8000,0x7FFF,0x0000 commits with exact values.
REQ-037 Gapped input: s_valid toggling 1/0 across a frame -> same result as REQ-032, with latency measured from the 4th accepted beat.
